// File: rtl/fpu_stack_responder_pkg.sv
// Shared definitions for the 8087 register-stack responder: opcodes, the
// real-indefinite constant, status/control bit positions and FSM encodings.
package fpu_stack_responder_pkg;

    localparam int DEPTH = 8;
    localparam int DW    = 80;

    localparam logic [DW-1:0] INDEF = 80'hFFFF_C000_0000_0000_0000;

    localparam logic [7:0] OP_FLD     = 8'h20;
    localparam logic [7:0] OP_FST     = 8'h21;
    localparam logic [7:0] OP_FSTP    = 8'h22;
    localparam logic [7:0] OP_FXCH    = 8'h23;
    localparam logic [7:0] OP_FFREE   = 8'h24;
    localparam logic [7:0] OP_FINCSTP = 8'h25;
    localparam logic [7:0] OP_FDECSTP = 8'h26;
    localparam logic [7:0] OP_FCLEX   = 8'h27;

    localparam int SW_B   = 15;
    localparam int SW_TOP = 11;
    localparam int SW_C1  = 9;
    localparam int SW_ES  = 7;
    localparam int SW_SF  = 6;
    localparam int SW_IE  = 0;
    localparam int CW_IM  = 0;

    localparam logic [15:0] CW_RESET = 16'h037F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_XCH2  = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0]    op;
        logic [2:0]    idx;
        logic [DW-1:0] data;
    } cmd_t;

    // Physical register holding ST(i).
    function automatic logic [2:0] st_phys(input logic [2:0] top, input logic [2:0] i);
        return top + i;
    endfunction

endpackage

// File: rtl/fpu_stack_regfile.sv
// 8 x 80-bit stack storage: two asynchronous read ports, one synchronous
// write port. Contents are not reset; validity is tracked by the parent's tags.
module fpu_stack_regfile
    import fpu_stack_responder_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [2:0]    wa,
    input  logic [DW-1:0] wd,
    input  logic [2:0]    ra_a,
    output logic [DW-1:0] rd_a,
    input  logic [2:0]    ra_b,
    output logic [DW-1:0] rd_b
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
    end

    assign rd_a = mem[ra_a];
    assign rd_b = mem[ra_b];

endmodule

// File: rtl/fpu_stack_responder.sv
// 8087 register-stack command responder: TOP, tags, flags and the
// execute/ready handshake. Define FPU_STACK_TAGWORD_EN to add tag_word_out.
module fpu_stack_responder
    import fpu_stack_responder_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          execute,
    input  logic [7:0]    instruction,
    input  logic [2:0]    stack_index,
    input  logic [DW-1:0] data_in,
    input  logic [15:0]   control_in,
    input  logic          control_write,
    output logic          ready,
    output logic          error,
    output logic [DW-1:0] data_out,
`ifdef FPU_STACK_TAGWORD_EN
    output logic [15:0]   tag_word_out,
`endif
    output logic [15:0]   status_out
);

    state_t        state, state_nx;
    cmd_t          cmd_q;
    logic [2:0]    top, top_nx, top_inc, top_dec, ia;
    logic [7:0]    tag, tag_nx;
    logic          im;
    logic          ie, ie_nx, sf, sf_nx, es, es_nx, c1, c1_nx;
    logic [DW-1:0] dout_nx;
    logic [DW-1:0] rd_a, rd_b, rd_a_q, rd_b_q;
    logic          rf_we;
    logic [2:0]    rf_wa;
    logic [DW-1:0] rf_wd;
    logic          x2_we_q, x2_we_nx;
    logic [DW-1:0] x2_wd_q, x2_wd_nx;
    logic          ovf, unf;

    assign ia      = st_phys(top, cmd_q.idx);
    assign top_inc = top + 3'd1;
    assign top_dec = top - 3'd1;

    fpu_stack_regfile u_rf (
        .clk  (clk),
        .we   (rf_we),
        .wa   (rf_wa),
        .wd   (rf_wd),
        .ra_a (ia),
        .rd_a (rd_a),
        .ra_b (top),
        .rd_b (rd_b)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (execute) state_nx = ST_READ;
            ST_READ:  state_nx = ST_WRITE;
            ST_WRITE: state_nx = (cmd_q.op == OP_FXCH) ? ST_XCH2 : ST_IDLE;
            ST_XCH2:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Commit decisions; only WRITE and XCH2 change architectural state.
    always_comb begin
        top_nx   = top;
        tag_nx   = tag;
        ie_nx    = ie;
        sf_nx    = sf;
        es_nx    = es;
        c1_nx    = c1;
        dout_nx  = data_out;
        rf_we    = 1'b0;
        rf_wa    = top;
        rf_wd    = cmd_q.data;
        x2_we_nx = 1'b0;
        x2_wd_nx = rd_a_q;
        ovf      = 1'b0;
        unf      = 1'b0;
        case (state)
            ST_WRITE: begin
                case (cmd_q.op)
                    OP_FLD: begin
                        if (tag[top_dec]) begin
                            ovf = 1'b1;
                            if (im) begin
                                top_nx = top_dec;
                                rf_we  = 1'b1;
                                rf_wa  = top_dec;
                                rf_wd  = INDEF;
                            end
                        end else begin
                            top_nx          = top_dec;
                            tag_nx[top_dec] = 1'b1;
                            rf_we           = 1'b1;
                            rf_wa           = top_dec;
                            rf_wd           = cmd_q.data;
                        end
                    end
                    OP_FST, OP_FSTP: begin
                        unf = ~tag[ia];
                        if (!unf)
                            dout_nx = rd_a_q;
                        else if (im)
                            dout_nx = INDEF;
                        if ((cmd_q.op == OP_FSTP) && (!unf || im)) begin
                            tag_nx[top] = 1'b0;
                            top_nx      = top_inc;
                        end
                    end
                    OP_FXCH: begin
                        // ST(i) is written now, ST(0) in XCH2 from the captured read.
                        unf = ~tag[ia] | ~tag[top];
                        if (!unf || im) begin
                            rf_we       = 1'b1;
                            rf_wa       = ia;
                            rf_wd       = tag[top] ? rd_b_q : INDEF;
                            tag_nx[ia]  = 1'b1;
                            tag_nx[top] = 1'b1;
                            x2_we_nx    = 1'b1;
                            x2_wd_nx    = tag[ia] ? rd_a_q : INDEF;
                        end
                    end
                    OP_FFREE:   tag_nx[ia] = 1'b0;
                    OP_FINCSTP: top_nx = top_inc;
                    OP_FDECSTP: top_nx = top_dec;
                    OP_FCLEX: begin
                        ie_nx = 1'b0;
                        sf_nx = 1'b0;
                    end
                    default: ie_nx = 1'b1;
                endcase
                if (ovf || unf) begin
                    ie_nx = 1'b1;
                    sf_nx = 1'b1;
                    c1_nx = ovf;
                end
                es_nx = ie_nx & ~im;
            end
            ST_XCH2: begin
                rf_we = x2_we_q;
                rf_wa = top;
                rf_wd = x2_wd_q;
            end
            default: ;
        endcase
        // A reset edge must never leave a partial register write behind.
        rf_we = rf_we & ~reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q    <= '0;
            top      <= 3'd0;
            tag      <= 8'h00;
            im       <= CW_RESET[CW_IM];
            ie       <= 1'b0;
            sf       <= 1'b0;
            es       <= 1'b0;
            c1       <= 1'b0;
            ready    <= 1'b1;
            data_out <= '0;
            rd_a_q   <= '0;
            rd_b_q   <= '0;
            x2_we_q  <= 1'b0;
            x2_wd_q  <= '0;
        end else begin
            if (control_write)
                im <= control_in[CW_IM];
            if (state == ST_IDLE && execute) begin
                cmd_q <= '{op: instruction, idx: stack_index, data: data_in};
                ready <= 1'b0;
            end
            if (state == ST_READ) begin
                rd_a_q <= rd_a;
                rd_b_q <= rd_b;
            end
            if (state == ST_WRITE) begin
                x2_we_q <= x2_we_nx;
                x2_wd_q <= x2_wd_nx;
            end
            if (state != ST_IDLE && state_nx == ST_IDLE)
                ready <= 1'b1;
            top      <= top_nx;
            tag      <= tag_nx;
            ie       <= ie_nx;
            sf       <= sf_nx;
            es       <= es_nx;
            c1       <= c1_nx;
            data_out <= dout_nx;
        end
    end

    assign error = es;

    always_comb begin
        status_out               = '0;
        status_out[SW_B]         = ~ready;
        status_out[SW_TOP +: 3]  = top;
        status_out[SW_C1]        = c1;
        status_out[SW_ES]        = es;
        status_out[SW_SF]        = sf;
        status_out[SW_IE]        = ie;
    end

`ifdef FPU_STACK_TAGWORD_EN
    always_comb begin
        tag_word_out = '0;
        for (int r = 0; r < DEPTH; r++)
            tag_word_out[2*r +: 2] = tag[r] ? 2'b00 : 2'b11;
    end
`endif

endmodule

// File: tb/tb_fpu_stack_responder.sv
// Scoreboard bench for fpu_stack_responder: directed commands push expected
// responses; a negedge monitor checks each completion as ready rises.
module tb_fpu_stack_responder;

    localparam logic [79:0] V1   = 80'h3FFF_8000_0000_0000_0000;
    localparam logic [79:0] V2   = 80'h4000_8000_0000_0000_0000;
    localparam logic [79:0] V3   = 80'h4000_C000_0000_0000_0000;
    localparam logic [79:0] V4   = 80'h4001_8000_0000_0000_0000;
    localparam logic [79:0] IND  = 80'hFFFF_C000_0000_0000_0000;
    localparam logic [7:0]  FLD  = 8'h20, FST = 8'h21, FSTP = 8'h22, FXCH = 8'h23;
    localparam logic [7:0]  FINC = 8'h25, FDEC = 8'h26, FCLEX = 8'h27;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        execute = 1'b0;
    logic [7:0]  instruction = 8'h00;
    logic [2:0]  stack_index = 3'd0;
    logic [79:0] data_in = '0;
    logic [15:0] control_in = 16'h0000;
    logic        control_write = 1'b0;
    logic        ready, error;
    logic [79:0] data_out;
    logic [15:0] status_out;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        cd;
        logic [79:0] d;
        logic [15:0] st;
        logic        er;
        int          lo;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    logic  pulse_busy = 1'b0;

    fpu_stack_responder dut (
        .clk           (clk),
        .reset         (reset),
        .execute       (execute),
        .instruction   (instruction),
        .stack_index   (stack_index),
        .data_in       (data_in),
        .control_in    (control_in),
        .control_write (control_write),
        .ready         (ready),
        .error         (error),
        .data_out      (data_out),
        .status_out    (status_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sw(input logic [2:0] t, input logic c1, input logic es,
                                       input logic sf, input logic ie);
        return {2'b00, t, 1'b0, c1, 1'b0, es, sf, 5'b00000, ie};
    endfunction

    function automatic logic [79:0] fval(input int k);
        logic [79:0] v;
        v = {16'h4000, 64'h0};
        v[7:0] = 8'(k);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_cw(input logic [15:0] v);
        @(negedge clk);
        control_in    = v;
        control_write = 1'b1;
        @(negedge clk);
        control_write = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk({nm, "_timeout"}, 80'(ready), 80'd1);
    endtask

    task automatic cmd(input logic [7:0] op, input logic [2:0] idx, input logic [79:0] d,
                       input string nm, input logic cd, input logic [79:0] ed,
                       input logic [15:0] st, input logic er, input int lo);
        exp_t e;
        wait_ready(nm);
        e.cd = cd; e.d = ed; e.st = st; e.er = er; e.lo = lo;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        instruction = op;
        stack_index = idx;
        data_in     = d;
        execute     = 1'b1;
        @(negedge clk);
        execute = 1'b0;
        if (pulse_busy) begin
            instruction = FDEC;
            execute     = 1'b1;
            @(negedge clk);
            execute = 1'b0;
        end
        wait_ready(nm);
    endtask

    // Monitor: a rising ready (outside reset) marks one completed command.
    initial begin
        logic prev_ready = 1'b1;
        int   low = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ready = 1'b1;
                low = 0;
            end else begin
                if (!ready) low++;
                if (ready && !prev_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_completion", 80'd1, 80'd0);
                    end else begin
                        exp_t  e;
                        string nm;
                        e  = exp_q.pop_front();
                        nm = name_q.pop_front();
                        if (e.cd) chk({nm, "_data"}, data_out, e.d);
                        chk({nm, "_status"}, 80'(status_out), 80'(e.st));
                        chk({nm, "_error"}, 80'(error), 80'(e.er));
                        if (e.lo > 0) chk({nm, "_ready_low"}, 80'(low), 80'(e.lo));
                    end
                    low = 0;
                end
                prev_ready = ready;
            end
        end
    end

    initial begin
        do_reset();
        chk("rst_ready", 80'(ready), 80'd1);
        chk("rst_error", 80'(error), 80'd0);
        chk("rst_data", data_out, 80'd0);
        chk("rst_status", 80'(status_out), 80'd0);

        // Push 1..4, read back in stack order.
        cmd(FLD, 3'd0, V1, "fld1", 1'b0, '0, sw(3'd7, 0, 0, 0, 0), 1'b0, 2);
        cmd(FLD, 3'd0, V2, "fld2", 1'b0, '0, sw(3'd6, 0, 0, 0, 0), 1'b0, 2);
        cmd(FLD, 3'd0, V3, "fld3", 1'b0, '0, sw(3'd5, 0, 0, 0, 0), 1'b0, 2);
        cmd(FLD, 3'd0, V4, "fld4", 1'b0, '0, sw(3'd4, 0, 0, 0, 0), 1'b0, 2);
        cmd(FST, 3'd0, '0, "fst0", 1'b1, V4, sw(3'd4, 0, 0, 0, 0), 1'b0, 2);
        cmd(FST, 3'd1, '0, "fst1", 1'b1, V3, sw(3'd4, 0, 0, 0, 0), 1'b0, 2);
        cmd(FST, 3'd2, '0, "fst2", 1'b1, V2, sw(3'd4, 0, 0, 0, 0), 1'b0, 2);
        cmd(FST, 3'd3, '0, "fst3", 1'b1, V1, sw(3'd4, 0, 0, 0, 0), 1'b0, 2);

        // [4,3,2,1] -> FXCH1 [3,4,2,1] -> FXCH2 [2,4,3,1] -> FXCH3 [1,4,3,2]
        cmd(FXCH, 3'd1, '0, "fxch1", 1'b0, '0, sw(3'd4, 0, 0, 0, 0), 1'b0, 3);
        cmd(FXCH, 3'd2, '0, "fxch2", 1'b0, '0, sw(3'd4, 0, 0, 0, 0), 1'b0, 3);
        cmd(FXCH, 3'd3, '0, "fxch3", 1'b0, '0, sw(3'd4, 0, 0, 0, 0), 1'b0, 3);
        cmd(FST, 3'd0, '0, "xst0", 1'b1, V1, sw(3'd4, 0, 0, 0, 0), 1'b0, 2);
        cmd(FST, 3'd1, '0, "xst1", 1'b1, V4, sw(3'd4, 0, 0, 0, 0), 1'b0, 2);
        cmd(FST, 3'd2, '0, "xst2", 1'b1, V3, sw(3'd4, 0, 0, 0, 0), 1'b0, 2);
        cmd(FST, 3'd3, '0, "xst3", 1'b1, V2, sw(3'd4, 0, 0, 0, 0), 1'b0, 2);

        // Masked overflow on the 9th push.
        do_reset();
        for (int k = 1; k <= 8; k++)
            cmd(FLD, 3'd0, fval(k), "ovm_fill", 1'b0, '0, sw(3'(8 - k), 0, 0, 0, 0), 1'b0, 2);
        cmd(FLD, 3'd0, fval(9), "ovm_fld9", 1'b0, '0, sw(3'd7, 1, 0, 1, 1), 1'b0, 2);
        cmd(FST, 3'd0, '0, "ovm_st0", 1'b1, IND, sw(3'd7, 1, 0, 1, 1), 1'b0, 2);
        cmd(FST, 3'd1, '0, "ovm_st1", 1'b1, fval(8), sw(3'd7, 1, 0, 1, 1), 1'b0, 2);

        // Unmasked overflow: no write, TOP unchanged, error raised.
        do_reset();
        set_cw(16'h037E);
        for (int k = 1; k <= 8; k++)
            cmd(FLD, 3'd0, fval(k), "ovu_fill", 1'b0, '0, sw(3'(8 - k), 0, 0, 0, 0), 1'b0, 2);
        cmd(FLD, 3'd0, fval(9), "ovu_fld9", 1'b0, '0, sw(3'd0, 1, 1, 1, 1), 1'b1, 2);
        cmd(FST, 3'd0, '0, "ovu_st0", 1'b1, fval(8), sw(3'd0, 1, 1, 1, 1), 1'b1, 2);

        // Masked underflow, FCLEX, unknown opcode, ignored busy strobe, pop.
        do_reset();
        cmd(FLD, 3'd0, V1, "uf_fld1", 1'b0, '0, sw(3'd7, 0, 0, 0, 0), 1'b0, 2);
        cmd(FLD, 3'd0, V2, "uf_fld2", 1'b0, '0, sw(3'd6, 0, 0, 0, 0), 1'b0, 2);
        cmd(FST, 3'd5, '0, "uf_st5", 1'b1, IND, sw(3'd6, 0, 0, 1, 1), 1'b0, 2);
        cmd(FCLEX, 3'd0, '0, "fclex", 1'b0, '0, sw(3'd6, 0, 0, 0, 0), 1'b0, 2);
        cmd(8'h3F, 3'd0, '0, "badop", 1'b0, '0, sw(3'd6, 0, 0, 0, 1), 1'b0, 2);
        cmd(FST, 3'd1, '0, "badop_st1", 1'b1, V1, sw(3'd6, 0, 0, 0, 1), 1'b0, 2);
        pulse_busy = 1'b1;
        cmd(FINC, 3'd0, '0, "busy_inc", 1'b0, '0, sw(3'd7, 0, 0, 0, 1), 1'b0, 2);
        pulse_busy = 1'b0;
        cmd(FSTP, 3'd0, '0, "fstp0", 1'b1, V1, sw(3'd0, 0, 0, 0, 1), 1'b0, 2);
        cmd(FST, 3'd0, '0, "popped_st0", 1'b1, IND, sw(3'd0, 0, 0, 1, 1), 1'b0, 2);

        // Reset while an FXCH sits in READ.
        do_reset();
        cmd(FLD, 3'd0, V1, "ab_fld1", 1'b0, '0, sw(3'd7, 0, 0, 0, 0), 1'b0, 2);
        cmd(FLD, 3'd0, V2, "ab_fld2", 1'b0, '0, sw(3'd6, 0, 0, 0, 0), 1'b0, 2);
        wait_ready("ab_fxch");
        @(negedge clk);
        instruction = FXCH;
        stack_index = 3'd1;
        execute     = 1'b1;
        @(negedge clk);
        execute = 1'b0;
        chk("ab_busy", 80'(ready), 80'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("ab_ready", 80'(ready), 80'd1);
        chk("ab_status", 80'(status_out), 80'd0);
        chk("ab_error", 80'(error), 80'd0);
        @(negedge clk);
        reset = 1'b0;
        cmd(FLD, 3'd0, V1, "ab_refld", 1'b0, '0, sw(3'd7, 0, 0, 0, 0), 1'b0, 2);
        cmd(FST, 3'd0, '0, "ab_st0", 1'b1, V1, sw(3'd7, 0, 0, 0, 0), 1'b0, 2);
        cmd(FST, 3'd1, '0, "ab_st1", 1'b1, IND, sw(3'd7, 0, 0, 1, 1), 1'b0, 2);

        repeat (3) @(negedge clk);
        chk("pending_expected", 80'(exp_q.size()), 80'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
